// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV64 multicycle control unit: opcode/funct fields,
// FSM states and the instruction classes the decoder produces.
package riscv_ctrl_pkg;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_D   = 3'b011;
   localparam logic [6:0] F7_ADD = 7'b0000000;
   localparam logic [6:0] F7_SUB = 7'b0100000;

   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   typedef enum logic [2:0] {
      CLS_R, CLS_I, CLS_LD, CLS_SD, CLS_ILL
   } instr_cls_t;
endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multicycle control unit (master) and the
// RV64 datapath (slave).
interface multicycle_control_unit_if #(parameter int COUNT_W = 16);
   logic               RUN;
   logic [31:0]        INSTR;
   logic               IR_LOAD;
   logic               reset_pc;
   logic               load_pc;
   logic               sub;
   logic               ULA_din2_sel;
   logic               RF_din_sel;
   logic               WE_RF;
   logic               WE_MEM;
   logic               HALTED;
   logic               ILLEGAL;
   logic [COUNT_W-1:0] RETIRED;

   modport master (
      input  RUN, INSTR,
      output IR_LOAD, reset_pc, load_pc, sub, ULA_din2_sel, RF_din_sel,
             WE_RF, WE_MEM, HALTED, ILLEGAL, RETIRED
   );

   modport slave (
      output RUN, INSTR,
      input  IR_LOAD, reset_pc, load_pc, sub, ULA_din2_sel, RF_din_sel,
             WE_RF, WE_MEM, HALTED, ILLEGAL, RETIRED
   );
endinterface

// File: rtl/instr_class_decoder.sv
// Combinational classifier for the supported subset (add/sub/addi/ld/sd);
// anything else is reported as CLS_ILL.
module instr_class_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [31:0] instr,
   output instr_cls_t  cls,
   output logic        sub
);
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       unused_fields;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   // Register indices and immediates only matter to the datapath.
   assign unused_fields = ^{instr[24:15], instr[11:7]};

   always_comb begin
      cls = CLS_ILL;
      sub = 1'b0;
      case (opcode)
         OP_R:
            if (funct3 == F3_ADD && (funct7 == F7_ADD || funct7 == F7_SUB)) begin
               cls = CLS_R;
               sub = (funct7 == F7_SUB);
            end
         OP_IMM:   if (funct3 == F3_ADD) cls = CLS_I;
         OP_LOAD:  if (funct3 == F3_D)   cls = CLS_LD;
         OP_STORE: if (funct3 == F3_D)   cls = CLS_SD;
         default:  cls = CLS_ILL;
      endcase
   end
endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle sequencer for the RV64 datapath: FSM, sticky illegal flag and
// retired-instruction counter. Strobes decode from registered state + INSTR.
module multicycle_control_unit
   import riscv_ctrl_pkg::*;
#(
   parameter int COUNT_W = 16
) (
   input  logic                        CLK,
   input  logic                        RST_N,
   multicycle_control_unit_if.master   bus
);
   state_t             state;
   instr_cls_t         cls;
   logic               sub_flag;
   logic               illegal;
   logic [COUNT_W-1:0] retired;
   logic               retire;
   logic               uses_imm;

   instr_class_decoder u_dec (
      .instr (bus.INSTR),
      .cls   (cls),
      .sub   (sub_flag)
   );

   assign retire   = (state == S_WB) || (state == S_MEM && cls == CLS_SD);
   assign uses_imm = (cls == CLS_I) || (cls == CLS_LD) || (cls == CLS_SD);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= S_INIT;
         illegal <= 1'b0;
         retired <= '0;
      end else begin
         if (retire) retired <= retired + COUNT_W'(1);
         case (state)
            S_INIT:   state <= S_IDLE;
            S_IDLE:   if (bus.RUN) state <= S_FETCH;
            S_FETCH:  state <= S_DECODE;
            S_DECODE:
               if (cls == CLS_ILL) begin
                  state   <= S_HALT;
                  illegal <= 1'b1;
               end else begin
                  state <= S_EXEC;
               end
            S_EXEC:   state <= (cls == CLS_LD || cls == CLS_SD) ? S_MEM : S_WB;
            S_MEM:    state <= (cls == CLS_LD) ? S_WB : S_IDLE;
            S_WB:     state <= S_IDLE;
            S_HALT:   state <= S_HALT;
            default:  state <= S_INIT;
         endcase
      end
   end

   // reset_pc is gated by RST_N so nothing strobes while reset is held.
   always_comb begin
      bus.reset_pc     = (state == S_INIT) && RST_N;
      bus.IR_LOAD      = (state == S_FETCH);
      bus.load_pc      = (state == S_DECODE) && (cls != CLS_ILL);
      bus.ULA_din2_sel = (state == S_EXEC || state == S_MEM || state == S_WB) && uses_imm;
      bus.sub          = (state == S_EXEC || state == S_WB) && sub_flag;
      bus.WE_MEM       = (state == S_MEM) && (cls == CLS_SD);
      bus.WE_RF        = (state == S_WB);
      bus.RF_din_sel   = (state == S_WB) && (cls == CLS_LD);
      bus.HALTED       = (state == S_HALT);
      bus.ILLEGAL      = illegal;
      bus.RETIRED      = retired;
   end
endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multicycle control FSM that sequences the RV64 instruction datapath (PC, instruction register, register file, ULA, data memory). It decodes the instruction register contents and drives every datapath strobe and mux select: `sub`, `WE_RF`, `WE_MEM`, `RF_din_sel`, `ULA_din2_sel`, `load_pc`, `reset_pc`, plus an IR load enable. It sits beside the datapath top level and replaces the hand-driven control inputs. It supports `add`, `sub`, `addi`, `ld` and `sd`, and halts on anything else.

## Interface
- COUNT_W, 16, width of the retired-instruction counter
- CLK  in  1  single clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- RUN  in  1  level; when high, a new instruction is started at each instruction boundary
- INSTR  in  32  instruction register output
- IR_LOAD  out  1  instruction register load enable
- reset_pc  out  1  PC reset strobe
- load_pc  out  1  PC load (PC+4, pc_next_sel=0)
- sub  out  1  ULA subtract select
- ULA_din2_sel  out  1  ULA operand 2 select: 1 = immediate, 0 = rs2
- RF_din_sel  out  1  register-file write data select: 1 = memory, 0 = ULA
- WE_RF  out  1  register-file write enable
- WE_MEM  out  1  data-memory write enable
- HALTED  out  1  FSM is in HALT
- ILLEGAL  out  1  sticky flag: an unsupported instruction was decoded
- RETIRED  out  COUNT_W  retired-instruction count

## Operation
- States: INIT, IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- INIT: `reset_pc`=1 for exactly one cycle, then IDLE.
- IDLE: if RUN=1, go to FETCH; otherwise stay.
- FETCH: `IR_LOAD`=1, then DECODE.
- DECODE:
  - Classify INSTR as R (opcode 0110011, funct3 000, funct7 0000000/0100000), I (0010011, funct3 000), LD (0000011, funct3 011), SD (0100011, funct3 011).
  - If legal: `load_pc`=1, then EXEC.
  - If illegal: no `load_pc`, set ILLEGAL, go to HALT.
- EXEC:
  - `ULA_din2_sel`=1 for I, LD and SD.
  - `sub`=1 only for R with funct7=0100000.
  - R and I go to WB; LD and SD go to MEM.
- MEM:
  - `ULA_din2_sel`=1.
  - SD: `WE_MEM`=1, instruction retires, next state IDLE.
  - LD: next state WB.
- WB:
  - `WE_RF`=1; `RF_din_sel`=1 for LD.
  - The operand selects (`ULA_din2_sel`, `sub`) keep their EXEC values.
  - Instruction retires, next state IDLE.
- Every control output is combinational from the registered state and INSTR, and is 0 outside the states listed above.
- RETIRED increments by 1 on the clock edge leaving the retiring state. It wraps from 2^COUNT_W−1 to 0.
- HALT is absorbing and can only be left through RST_N.

## Timing
- Reset values:
  - state=INIT
  - ILLEGAL=0, RETIRED=0, HALTED=0
  - all strobes 0 while RST_N=0
  - `reset_pc` rises in the first cycle after RST_N deasserts
- Latency from IDLE with RUN=1:
  - R/I: FETCH, DECODE, EXEC, WB, so 5 cycles including IDLE
  - LD: 6 cycles
  - SD: 5 cycles
  - With RUN held high, retirement rate is one instruction per 5, 6 or 5 cycles respectively.
- RUN is sampled only in IDLE. Dropping RUN mid-instruction does not abort; the instruction completes and the FSM then parks in IDLE.
- `WE_RF` and `WE_MEM` are never high in the same cycle, and each is high for at most one cycle per instruction.
- `load_pc` is high exactly once per legal instruction (DECODE), and one cycle after `IR_LOAD`.
- Asserting RST_N low in any state forces INIT immediately. The aborted instruction performs no further writes and does not retire.
- When a retirement and the wrap-around occur on the same edge, RETIRED=0.

## Structure
- Package `riscv_ctrl_pkg`:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE)
  - funct3/funct7 constants
  - state enum
  - instruction-class enum {CLS_R, CLS_I, CLS_LD, CLS_SD, CLS_ILL}
- Sub-module `instr_class_decoder`: combinational, INSTR in, class plus `sub` flag out. The FSM and the retire counter live in `multicycle_control_unit`.

## Test plan
- Release reset, RUN=0 → `reset_pc`=1 for one cycle, then IDLE; all strobes 0, RETIRED=0.
- RUN=1, INSTR=`add` x3,x1,x2 (0x002081B3) → `IR_LOAD`, `load_pc`, `WE_RF` in cycles 2, 3, 5 after IDLE; `sub`=0, `ULA_din2_sel`=0; RETIRED=1.
- INSTR=`sub` (0x402081B3) → `sub`=1 in EXEC and WB. INSTR=`ld` x5,8(x1) (0x0080B283) → `WE_RF` with `RF_din_sel`=1 in cycle 6, `WE_MEM` never high.
- INSTR=`sd` x5,16(x1) (0x0050B823) → `WE_MEM`=1 for one cycle in MEM, `WE_RF` never high; RETIRED increments.
- INSTR=0xFFFFFFFF → HALTED=1, ILLEGAL=1, no `load_pc`; state holds across RUN toggles until RST_N pulse.
- COUNT_W=2, four `addi` retirements → RETIRED 1, 2, 3, 0. RST_N pulsed low in MEM of `sd` → no `WE_MEM`, RETIRED=0, INIT.
